vga_clear_sequencer: RTL and testbench

Produces the clear-screen (black) pixel stream feeding the VGA clear/regular pixel mux, and drives that mux's select line. On a start pulse it sweeps every pixel of the 160x120 frame once, one pixel per clock, asserting plot. It holds the select on "clear" for the whole sweep, then hands the VGA back to the regular game-render stream and pulses done. Sits between the top-level game controller (start/done) and the pixel mux plus VGA adapter.

---
 rtl/vga_clear_sequencer.sv | 151 +++++++++++++++
 tb/tb_vga_clear_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_clear_sequencer.sv
// vga_clear_sequencer
// Generates the black clear-screen pixel stream for the VGA clear/regular mux
// and drives the mux select. A start pulse in IDLE sweeps the frame once,
// one pixel per clock in row-major order, then pulses done for one cycle.
//
// Optional build macro CLEAR_REGION_EN: adds regionX0/regionY0/regionX1/regionY1
// inputs, latched on an accepted start, restricting the sweep to that
// inclusive rectangle. An empty rectangle (X0>X1 or Y0>Y1) skips straight
// to DONE. Without the macro the full SCREEN_WIDTH x SCREEN_HEIGHT frame is swept.
module vga_clear_sequencer #(
    parameter int SCREEN_WIDTH = 160,
    parameter int SCREEN_HEIGHT = 120,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
`ifdef CLEAR_REGION_EN
    input  logic [7:0] regionX0,
    input  logic [6:0] regionY0,
    input  logic [7:0] regionX1,
    input  logic [6:0] regionY1,
`endif
    output logic [7:0] xClear,
    output logic [6:0] yClear,
    output logic [2:0] colorClear,
    output logic       plotClear,
    output logic       sendClearOrRegular,
    output logic       busy,
    output logic       done
);

    // Last valid coordinates of the full frame, sized to the port widths so
    // the end-of-row / end-of-frame tests are explicit compares, not wraps.
    localparam logic [7:0] X_MAX = 8'(SCREEN_WIDTH - 1);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT state;

    // Rectangle requested at the moment start is accepted.
    logic [7:0] reqX0;
    logic [7:0] reqX1;
    logic [6:0] reqY0;
    logic [6:0] reqY1;
    logic       reqEmpty;

    // Rectangle bounds held for the duration of a sweep, so the region
    // inputs may change freely once the sweep has begun.
    logic [7:0] xFirstReg;
    logic [7:0] xLastReg;
    logic [6:0] yLastReg;

`ifdef CLEAR_REGION_EN
    assign reqX0 = regionX0;
    assign reqX1 = regionX1;
    assign reqY0 = regionY0;
    assign reqY1 = regionY1;
`else
    assign reqX0 = 8'd0;
    assign reqX1 = X_MAX;
    assign reqY0 = 7'd0;
    assign reqY1 = Y_MAX;
`endif

    assign reqEmpty = (reqX0 > reqX1) || (reqY0 > reqY1);

    // Sweep FSM: state, pixel counters and every output are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            xClear             <= 8'd0;
            yClear             <= 7'd0;
            colorClear         <= CLEAR_COLOR;
            plotClear          <= 1'b0;
            sendClearOrRegular <= 1'b1;
            busy               <= 1'b0;
            done               <= 1'b0;
            xFirstReg          <= 8'd0;
            xLastReg           <= X_MAX;
            yLastReg           <= Y_MAX;
        end else begin
            case (state)
                IDLE: begin
                    done       <= 1'b0;
                    colorClear <= CLEAR_COLOR;
                    if (start) begin
                        xFirstReg <= reqX0;
                        xLastReg  <= reqX1;
                        yLastReg  <= reqY1;
                        if (reqEmpty) begin
                            // Nothing to draw: report completion straight away.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state              <= CLEAR;
                            xClear             <= reqX0;
                            yClear             <= reqY0;
                            plotClear          <= 1'b1;
                            sendClearOrRegular <= 1'b0;
                            busy               <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    // start is deliberately ignored while sweeping.
                    if (xClear == xLastReg) begin
                        if (yClear == yLastReg) begin
                            // Last pixel shown this cycle; hand the VGA back.
                            state              <= DONE;
                            xClear             <= 8'd0;
                            yClear             <= 7'd0;
                            plotClear          <= 1'b0;
                            sendClearOrRegular <= 1'b1;
                            busy               <= 1'b0;
                            done               <= 1'b1;
                        end else begin
                            xClear <= xFirstReg;
                            yClear <= yClear + 7'd1;
                        end
                    end else begin
                        xClear <= xClear + 8'd1;
                    end
                end

                DONE: begin
                    // Single-cycle completion pulse; start is not honoured here.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state              <= IDLE;
                    xClear             <= 8'd0;
                    yClear             <= 7'd0;
                    plotClear          <= 1'b0;
                    sendClearOrRegular <= 1'b1;
                    busy               <= 1'b0;
                    done               <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_clear_sequencer.sv
// Self-checking bench for vga_clear_sequencer.
// The stimulus side predicts, at each accepted start, the full list of pixels
// (with the cycle each must appear in) and the done cycle, and queues them.
// A monitor on the falling edge pops and compares whatever the DUT presents.
module tb_vga_clear_sequencer;

    localparam int SW = 160;
    localparam int SH = 120;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] xClear;
    logic [6:0] yClear;
    logic [2:0] colorClear;
    logic       plotClear;
    logic       sendClearOrRegular;
    logic       busy;
    logic       done;

    // Region requested by the bench (full frame unless a region test sets it).
    int gX0 = 0;
    int gX1 = SW - 1;
    int gY0 = 0;
    int gY1 = SH - 1;

`ifdef CLEAR_REGION_EN
    logic [7:0] rX0;
    logic [7:0] rX1;
    logic [6:0] rY0;
    logic [6:0] rY1;
    assign rX0 = gX0[7:0];
    assign rX1 = gX1[7:0];
    assign rY0 = gY0[6:0];
    assign rY1 = gY1[6:0];
`endif

    vga_clear_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
`ifdef CLEAR_REGION_EN
        .regionX0           (rX0),
        .regionY0           (rY0),
        .regionX1           (rX1),
        .regionY1           (rY1),
`endif
        .xClear             (xClear),
        .yClear             (yClear),
        .colorClear         (colorClear),
        .plotClear          (plotClear),
        .sendClearOrRegular (sendClearOrRegular),
        .busy               (busy),
        .done               (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int c;
        int x;
        int y;
    } pixT;

    pixT pixQ[$];
    int  doneQ[$];
    int  freeAt = 0;
    int  checks = 0;
    int  errors = 0;
    bit  monOn = 1'b0;
    pixT p;

    // Reference: a start accepted in cycle c lists every pixel of the
    // rectangle row by row from cycle c+1; done follows the last pixel and
    // the sequencer can take a new start two cycles after that.
    task automatic accept(input int c);
        int n;
        pixT e;
        n = 0;
        if (gX0 > gX1 || gY0 > gY1) begin
            doneQ.push_back(c + 1);
            freeAt = c + 2;
        end else begin
            for (int yy = gY0; yy <= gY1; yy++) begin
                for (int xx = gX0; xx <= gX1; xx++) begin
                    e.c = c + 1 + n;
                    e.x = xx;
                    e.y = yy;
                    pixQ.push_back(e);
                    n++;
                end
            end
            doneQ.push_back(c + 1 + n);
            freeAt = c + n + 2;
        end
    endtask

    // Drive one cycle of inputs and update the expectation queues.
    task automatic step(input logic s, input logic r);
        start = s;
        reset = r;
        if (r) begin
            while (pixQ.size() > 0 && pixQ[$].c > cyc) void'(pixQ.pop_back());
            while (doneQ.size() > 0 && doneQ[$] > cyc) void'(doneQ.pop_back());
            freeAt = cyc + 1;
        end else if (s && cyc >= freeAt) begin
            accept(cyc);
        end
        @(posedge clock);
        #1;
    endtask

    // Run until every queued expectation has been seen, with stray start
    // pulses while busy (always one in the DONE cycle) and, optionally,
    // region inputs scrambled to show they are latched.
    task automatic waitDrain(input int budget, input bit glitch, input bit scramble);
        int k;
        logic g;
        k = 0;
        while ((pixQ.size() > 0 || doneQ.size() > 0) && k < budget) begin
            g = glitch && (cyc < freeAt) &&
                ((cyc == freeAt - 1) || ($urandom_range(0, 199) == 0));
            if (scramble && $urandom_range(0, 3) == 0) begin
                gX0 = $urandom_range(0, 159);
                gY0 = $urandom_range(0, 119);
            end
            step(g, 1'b0);
            k++;
        end
        checks++;
        if (pixQ.size() > 0 || doneQ.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout pending_pixels=%0d pending_done=%0d required 0 0",
                     pixQ.size(), doneQ.size());
            pixQ.delete();
            doneQ.delete();
        end
    endtask

    // Monitor: compare presented pixels / done against the queued expectations.
    always @(negedge clock) begin
        if (monOn) begin
            while (pixQ.size() > 0 && pixQ[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pixel cycle=%0d required (%0d,%0d)", pixQ[0].c, pixQ[0].x, pixQ[0].y);
                void'(pixQ.pop_front());
            end
            while (doneQ.size() > 0 && doneQ[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_done required cycle=%0d", doneQ[0]);
                void'(doneQ.pop_front());
            end
            checks++;
            if (plotClear === 1'b1) begin
                if (pixQ.size() == 0 || pixQ[0].c != cyc) begin
                    errors++;
                    $display("FAIL unexpected_plot cycle=%0d got (%0d,%0d) required no plot", cyc, xClear, yClear);
                end else begin
                    p = pixQ.pop_front();
                    if (xClear !== p.x[7:0] || yClear !== p.y[6:0] || colorClear !== 3'b000 ||
                        sendClearOrRegular !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL pixel cycle=%0d got x=%0d y=%0d col=%0d sel=%b busy=%b done=%b required x=%0d y=%0d col=0 sel=0 busy=1 done=0",
                                 cyc, xClear, yClear, colorClear, sendClearOrRegular, busy, done, p.x, p.y);
                    end
                end
            end else begin
                if (pixQ.size() > 0 && pixQ[0].c == cyc) begin
                    errors++;
                    $display("FAIL missing_plot cycle=%0d got plot=%b required (%0d,%0d)", cyc, plotClear, pixQ[0].x, pixQ[0].y);
                    void'(pixQ.pop_front());
                end else if (plotClear !== 1'b0 || sendClearOrRegular !== 1'b1 || busy !== 1'b0 ||
                             xClear !== 8'd0 || yClear !== 7'd0 || colorClear !== 3'b000) begin
                    errors++;
                    $display("FAIL idle_outputs cycle=%0d got plot=%b sel=%b busy=%b x=%0d y=%0d col=%0d required 0 1 0 0 0 0",
                             cyc, plotClear, sendClearOrRegular, busy, xClear, yClear, colorClear);
                end
            end
            checks++;
            if (done === 1'b1) begin
                if (doneQ.size() == 0 || doneQ[0] != cyc) begin
                    errors++;
                    $display("FAIL unexpected_done cycle=%0d got done=1 required 0", cyc);
                end else begin
                    void'(doneQ.pop_front());
                end
            end else if (doneQ.size() > 0 && doneQ[0] == cyc) begin
                errors++;
                $display("FAIL done_pulse cycle=%0d got done=%b required 1", cyc, done);
                void'(doneQ.pop_front());
            end
        end
    end

    initial begin
        int t0;
        @(posedge clock);
        #1;
        // Reset for three cycles, then idle.
        repeat (3) step(1'b0, 1'b1);
        monOn = 1'b1;
        repeat (10) step(1'b0, 1'b0);

        // Full sweep with a stray start at pixel (80,60).
        t0 = cyc;
        step(1'b1, 1'b0);
        while (cyc < t0 + 1 + 60 * SW + 80) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        waitDrain(25000, 1'b1, 1'b0);
        repeat ($urandom_range(1, 6)) step(1'b0, 1'b0);

        // Reset at pixel (10,5), then a fresh sweep from (0,0).
        t0 = cyc;
        step(1'b1, 1'b0);
        while (cyc < t0 + 1 + 5 * SW + 10) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat ($urandom_range(2, 5)) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        waitDrain(25000, 1'b1, 1'b0);

        // start held high: back-to-back sweeps.
        repeat (SW * SH + 2 + 5) step(1'b1, 1'b0);
        waitDrain(25000, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0);

`ifdef CLEAR_REGION_EN
        gX0 = 10; gY0 = 20; gX1 = 12; gY1 = 21;
        step(1'b1, 1'b0);
        waitDrain(100, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        gX0 = 5; gY0 = 0; gX1 = 4; gY1 = 0;
        step(1'b1, 1'b0);
        waitDrain(100, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            gX0 = $urandom_range(2, 150);
            gX1 = gX0 + $urandom_range(0, 8) - 2;
            gY0 = $urandom_range(2, 110);
            gY1 = gY0 + $urandom_range(0, 5) - 1;
            step(1'b1, 1'b0);
            waitDrain(200, 1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0);
        end
`endif

        repeat (5) step(1'b0, 1'b0);
        checks++;
        if (pixQ.size() != 0 || doneQ.size() != 0) begin
            errors++;
            $display("FAIL final_queues got %0d %0d required 0 0", pixQ.size(), doneQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
